// File: rtl/mtm_alu_deserializer_p.sv
`default_nettype none
// ============================================================================
// Module   : mtm_alu_deserializer_p
// Function : Serial frame deserializer for the MTM ALU. It assembles NUM_OPS
//            operands and a command byte, and checks framing, CRC4 and opcode.
//            The optional opcode check is enabled by MTM_DES_OPCODE_CHECK_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module mtm_alu_deserializer_p #(
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sin,
  output logic [NUM_OPS*DATA_W-1:0] op_data,
  output logic [7:0]                ctl,
  output logic                      out_valid,
  output logic                      err_valid
);

  localparam int NB  = NUM_OPS * DATA_W / 8;
  localparam int OPW = NUM_OPS * DATA_W;
  localparam int CW  = $clog2(NB + 1);
  localparam logic [CW-1:0] NB_C = CW'(NB);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FLAG    = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_DERR    = 3'd5;
  localparam logic [2:0] S_RESYNC  = 3'd6;

  localparam logic [7:0] CTL_DATAERR = 8'b11001001;
  localparam logic [7:0] CTL_CRCERR  = 8'b10100101;
  localparam logic [7:0] CTL_OPERR   = 8'b10010011;

  logic [2:0]     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [OPW-1:0] shift_q, shift_d;
  logic [7:0]     cmd_q, cmd_d;
  logic [3:0]     crc_q, crc_d;
  logic [3:0]     ones_q, ones_d;
  logic [OPW-1:0] op_data_q, op_data_d;
  logic [7:0]     ctl_q, ctl_d;
  logic           out_valid_q, out_valid_d;
  logic           err_valid_q, err_valid_d;
  logic           is_cmd, crc_ok, op_ok, frame_ok;

  // Serial CRC4, x^4+x+1
  function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  assign is_cmd = (byte_cnt_q == NB_C);
  assign crc_ok = (crc_q == cmd_q[3:0]);
`ifdef MTM_DES_OPCODE_CHECK_EN
  assign op_ok  = ~cmd_q[5];
`else
  assign op_ok  = 1'b1;
`endif
  assign frame_ok = crc_ok & op_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      cmd_q       <= '0;
      crc_q       <= '0;
      ones_q      <= '0;
      op_data_q   <= '0;
      ctl_q       <= 8'hFF;
      out_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      cmd_q       <= cmd_d;
      crc_q       <= crc_d;
      ones_q      <= ones_d;
      op_data_q   <= op_data_d;
      ctl_q       <= ctl_d;
      out_valid_q <= out_valid_d;
      err_valid_q <= err_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    cmd_d      = cmd_q;
    crc_d      = crc_q;
    ones_d     = 4'd0;
    case (state_q)
      S_IDLE: if (!sin) state_d = S_FLAG;
      S_FLAG: state_d = (sin != is_cmd) ? S_DERR : S_PAYLOAD;
      S_PAYLOAD: begin
        // Cmd CRC covers a constant 1 in place of bit 7, then op bits only
        if (is_cmd) begin
          cmd_d = {cmd_q[6:0], sin};
          if (bit_cnt_q == 3'd0)      crc_d = crc4_step(crc_q, 1'b1);
          else if (bit_cnt_q <= 3'd3) crc_d = crc4_step(crc_q, sin);
        end else begin
          shift_d = {shift_q[OPW-2:0], sin};
          crc_d   = crc4_step(crc_q, sin);
        end
        if (bit_cnt_q == 3'd7) state_d = S_STOP;
        else                   bit_cnt_d = bit_cnt_q + 3'd1;
      end
      S_STOP: begin
        bit_cnt_d = 3'd0;
        if (!sin) state_d = S_DERR;
        else if (is_cmd) state_d = S_CHECK;
        else begin
          byte_cnt_d = byte_cnt_q + CW'(1);
          state_d    = S_IDLE;
        end
      end
      S_CHECK: begin
        byte_cnt_d = '0;
        crc_d      = 4'd0;
        // A start bit right after the cmd stop bit begins the next frame
        if (!frame_ok) state_d = S_RESYNC;
        else           state_d = sin ? S_IDLE : S_FLAG;
      end
      S_DERR: begin
        bit_cnt_d  = 3'd0;
        byte_cnt_d = '0;
        crc_d      = 4'd0;
        state_d    = S_RESYNC;
      end
      S_RESYNC: begin
        if (sin) begin
          if (ones_q == 4'd10) state_d = S_IDLE;
          else                 ones_d  = ones_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = 1'b0;
    err_valid_d = 1'b0;
    ctl_d       = ctl_q;
    op_data_d   = op_data_q;
    case (state_q)
      S_CHECK: begin
        if (!crc_ok) begin
          err_valid_d = 1'b1;
          ctl_d       = CTL_CRCERR;
        end else if (!op_ok) begin
          err_valid_d = 1'b1;
          ctl_d       = CTL_OPERR;
        end else begin
          out_valid_d = 1'b1;
          ctl_d       = {1'b0, cmd_q[6:0]};
          op_data_d   = shift_q;
        end
      end
      S_DERR: begin
        err_valid_d = 1'b1;
        ctl_d       = CTL_DATAERR;
      end
      default: ;
    endcase
  end

  assign op_data   = op_data_q;
  assign ctl       = ctl_q;
  assign out_valid = out_valid_q;
  assign err_valid = err_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_deserializer_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtm_alu_deserializer_p
// Function : Self-checking bench for mtm_alu_deserializer_p (default and
//            16x3 instances); honours MTM_DES_OPCODE_CHECK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtm_alu_deserializer_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, sin_a, ov_a, ev_a;
  logic [63:0] op_a;
  logic [7:0]  ctl_a;
  logic        rst_b_n, sin_b, ov_b, ev_b;
  logic [47:0] op_b;
  logic [7:0]  ctl_b;

  mtm_alu_deserializer_p dut_a (
    .clk(clk), .rst_n(rst_a_n), .sin(sin_a),
    .op_data(op_a), .ctl(ctl_a), .out_valid(ov_a), .err_valid(ev_a)
  );

  mtm_alu_deserializer_p #(.DATA_W(16), .NUM_OPS(3)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .sin(sin_b),
    .op_data(op_b), .ctl(ctl_b), .out_valid(ov_b), .err_valid(ev_b)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit          ok;
    logic [7:0]  ctl;
    logic [63:0] data;
  } pulse_t;

  int     checks   = 0;
  int     failures = 0;
  bit     mon_en   = 1'b0;
  pulse_t got_a[$];
  pulse_t got_b[$];
  pulse_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Record every pulse from both DUTs; valid and error must never coincide
  always @(negedge clk) begin
    if (mon_en) begin
      if (ov_a || ev_a) got_a.push_back('{ok: ov_a, ctl: ctl_a, data: op_a});
      if (ov_b || ev_b) got_b.push_back('{ok: ov_b, ctl: ctl_b, data: {16'h0, op_b}});
      chk("excl_a", {63'h0, ov_a & ev_a}, 64'h0);
      chk("excl_b", {63'h0, ov_b & ev_b}, 64'h0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // CRC as polynomial remainder of (message * x^4) mod (x^4+x+1)
  function automatic logic [3:0] crc_ref(input bq_t bytes, input logic [2:0] op);
    bit       m[$];
    bit [4:0] g;
    int       n;
    g = 5'b10011;
    foreach (bytes[i]) for (int j = 7; j >= 0; j--) m.push_back(bytes[i][j]);
    m.push_back(1'b1);
    for (int j = 2; j >= 0; j--) m.push_back(op[j]);
    repeat (4) m.push_back(1'b0);
    n = m.size();
    for (int i = 0; i <= n - 5; i++)
      if (m[i]) for (int j = 0; j < 5; j++) m[i+j] = m[i+j] ^ g[4-j];
    return {m[n-4], m[n-3], m[n-2], m[n-1]};
  endfunction

  function automatic logic [63:0] pack(input bq_t bytes);
    logic [63:0] d;
    d = '0;
    foreach (bytes[i]) d = {d[55:0], bytes[i]};
    return d;
  endfunction

  task automatic send_bit(input int w, input logic b);
    @(negedge clk);
    if (w == 0) sin_a = b; else sin_b = b;
  endtask

  task automatic send_pkt(input int w, input logic flag, input logic [7:0] d);
    send_bit(w, 1'b0);
    send_bit(w, flag);
    for (int i = 7; i >= 0; i--) send_bit(w, d[i]);
    send_bit(w, 1'b1);
  endtask

  task automatic send_frame(input int w, input bq_t bytes, input logic [7:0] cmd);
    foreach (bytes[i]) send_pkt(w, 1'b0, bytes[i]);
    send_pkt(w, 1'b1, cmd);
  endtask

  task automatic idle(input int w, input int n);
    repeat (n) send_bit(w, 1'b1);
  endtask

  task automatic expect_pulse(input int w, input bit ok, input logic [7:0] c,
                              input logic [63:0] d, input string tag);
    pulse_t p;
    int     n;
    n = 0;
    while (((w == 0) ? got_a.size() : got_b.size()) == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (((w == 0) ? got_a.size() : got_b.size()) == 0) begin
      chk({tag, "_timeout"}, 64'h0, 64'h1);
    end else begin
      p = (w == 0) ? got_a.pop_front() : got_b.pop_front();
      chk({tag, "_kind"}, {63'h0, p.ok}, {63'h0, ok});
      chk({tag, "_ctl"}, {56'h0, p.ctl}, {56'h0, c});
      chk({tag, "_data"}, p.data, d);
    end
  endtask

  task automatic expect_quiet(input int w, input int cycles, input string tag);
    repeat (cycles) @(negedge clk);
    chk(tag, 64'((w == 0) ? got_a.size() : got_b.size()), 64'h0);
  endtask

  bq_t         bytes, rb;
  logic [3:0]  crc;
  logic [7:0]  cmd, cmd0;
  logic [2:0]  op;
  logic [63:0] last_a;
  bit          bad, ok;

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; sin_a = 1'b1; sin_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_op_a", op_a, 64'h0);
    chk("rst_ctl_a", {56'h0, ctl_a}, 64'hFF);
    chk("rst_ov_a", {63'h0, ov_a}, 64'h0);
    chk("rst_ev_a", {63'h0, ev_a}, 64'h0);
    chk("rst_op_b", {16'h0, op_b}, 64'h0);
    chk("rst_ctl_b", {56'h0, ctl_b}, 64'hFF);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    mon_en = 1'b1;
    idle(0, 3);

    // Directed frame with exact pulse timing
    bytes = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
    crc   = crc_ref(bytes, 3'b000);
    cmd0  = {1'b0, 3'b000, crc};
    send_frame(0, bytes, cmd0);
    @(negedge clk);
    chk("t1_early", {63'h0, ov_a}, 64'h0);
    @(negedge clk);
    chk("t1_ov", {63'h0, ov_a}, 64'h1);
    chk("t1_ev", {63'h0, ev_a}, 64'h0);
    chk("t1_op", op_a, 64'h00000002_00000001);
    chk("t1_ctl", {56'h0, ctl_a}, {56'h0, cmd0});
    @(negedge clk);
    chk("t1_width", {63'h0, ov_a}, 64'h0);
    last_a = 64'h00000002_00000001;
    expect_pulse(0, 1'b1, cmd0, last_a, "t1");

    // CRC bit 0 flipped
    send_frame(0, bytes, cmd0 ^ 8'h01);
    expect_pulse(0, 1'b0, 8'b10100101, last_a, "crcerr");
    idle(0, 14);

    // Illegal opcode with correct CRC
    cmd = {1'b0, 3'b010, crc_ref(bytes, 3'b010)};
    send_frame(0, bytes, cmd);
`ifdef MTM_DES_OPCODE_CHECK_EN
    expect_pulse(0, 1'b0, 8'b10010011, last_a, "operr");
`else
    expect_pulse(0, 1'b1, cmd, last_a, "op_pass");
`endif
    idle(0, 14);

    // Cmd flag as 5th packet, then the rest of the frame
    for (int i = 0; i < 4; i++) send_pkt(0, 1'b0, bytes[i]);
    send_pkt(0, 1'b1, cmd0);
    for (int i = 4; i < 8; i++) send_pkt(0, 1'b0, bytes[i]);
    send_pkt(0, 1'b1, cmd0);
    idle(0, 14);
    expect_pulse(0, 1'b0, 8'b11001001, last_a, "dataerr");
    expect_quiet(0, 5, "dataerr_single");
    send_frame(0, bytes, cmd0);
    expect_pulse(0, 1'b1, cmd0, last_a, "after_resync");
    idle(0, 2);

    // Random frames, including back-to-back successes
    for (int k = 0; k < 12; k++) begin
      rb = {};
      repeat (8) rb.push_back(8'($urandom));
      op  = 3'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      crc = crc_ref(rb, op);
      cmd = {1'b0, op, bad ? (crc ^ 4'($urandom_range(1, 15))) : crc};
      ok  = !bad;
`ifdef MTM_DES_OPCODE_CHECK_EN
      if (!bad && op[1]) ok = 1'b0;
`endif
      if (ok) begin
        last_a = pack(rb);
        exp_q.push_back('{ok: 1'b1, ctl: cmd, data: last_a});
      end else begin
        exp_q.push_back('{ok: 1'b0, ctl: bad ? 8'b10100101 : 8'b10010011, data: last_a});
      end
      send_frame(0, rb, cmd);
      idle(0, ok ? $urandom_range(0, 2) : 14);
    end
    foreach (exp_q[i]) expect_pulse(0, exp_q[i].ok, exp_q[i].ctl, exp_q[i].data, "rand");
    expect_quiet(0, 20, "rand_no_extra");

    // 16x3 instance: byte ordering, then reset mid-frame
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    cmd   = {1'b0, 3'b001, crc_ref(bytes, 3'b001)};
    send_frame(1, bytes, cmd);
    expect_pulse(1, 1'b1, cmd, 64'h0000_112233445566, "b_frame");
    idle(1, 3);
    for (int i = 0; i < 3; i++) send_pkt(1, 1'b0, bytes[i]);
    send_bit(1, 1'b0);
    send_bit(1, 1'b0);
    send_bit(1, 1'b1);
    @(negedge clk);
    rst_b_n = 1'b0;
    sin_b   = 1'b1;
    @(negedge clk);
    rst_b_n = 1'b1;
    chk("b_rst_op", {16'h0, op_b}, 64'h0);
    chk("b_rst_ctl", {56'h0, ctl_b}, 64'hFF);
    chk("b_rst_ov", {63'h0, ov_b}, 64'h0);
    chk("b_rst_ev", {63'h0, ev_b}, 64'h0);
    expect_quiet(1, 30, "b_rst_quiet");
    rb = {};
    repeat (6) rb.push_back(8'($urandom));
    cmd = {1'b0, 3'b100, crc_ref(rb, 3'b100)};
    send_frame(1, rb, cmd);
    expect_pulse(1, 1'b1, cmd, pack(rb), "b_after_rst");
    expect_quiet(1, 10, "b_final_quiet");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
